// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register and the ex/mem stages.
//   - pipe_state_e : occupancy of a stage (EMPTY / FULL / SKIDFULL)
//   - PIPE_DATA_W  : default payload width
//   - PL_*         : bit offsets/widths of the packed payload fields.
//                    A zero payload is a NOP, because cmdtype 0 means "no command".
package pipe_pkg;

  localparam int PIPE_DATA_W = 110;

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_FULL     = 2'd1,
    ST_SKIDFULL = 2'd2
  } pipe_state_e;

  // Payload layout, LSB first.
  localparam int PL_CMDTYPE_LSB  = 0;
  localparam int PL_CMDTYPE_W    = 8;
  localparam int PL_SDATA_LSB    = 8;
  localparam int PL_SDATA_W      = 32;
  localparam int PL_MADDR_LSB    = 40;
  localparam int PL_MADDR_W      = 32;
  localparam int PL_WE_LSB       = 72;
  localparam int PL_WE_W         = 1;
  localparam int PL_RSD_DATA_LSB = 73;
  localparam int PL_RSD_DATA_W   = 32;
  localparam int PL_RSD_ADDR_LSB = 105;
  localparam int PL_RSD_ADDR_W   = 5;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter. The count sticks at all-ones and never wraps.
// Ports:
//   clk_in - clock (rising edge)
//   rst_in - asynchronous active-high reset, clears the count
//   inc    - add one on this edge, unless the count is already saturated
//   cnt    - current count
module sat_counter
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + ONE;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with an optional skid entry, flush and a bubble counter.
// Ports:
//   clk_in, rst_in       - clock, asynchronous active-high reset
//   rdy_in               - global enable; 0 freezes everything (flush ignored)
//   flush_in             - kill both entries (wins over accept and drain)
//   up_valid/up_data     - upstream payload; up_ready = stage can accept
//   dn_valid/dn_data     - downstream payload (main register); dn_ready = downstream takes
//   bubble_cnt           - saturating count of enabled cycles with dn_valid=0
//
// state        | meaning
// -------------+------------------------------------------------------
// ST_EMPTY     | no payload held; dn_data is all-zero (NOP bubble)
// ST_FULL      | main register holds the oldest payload
// ST_SKIDFULL  | main and skid both valid; skid is younger (SKID=1 only)
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              flush_in,
  input  logic              up_valid,
  input  logic [DATA_W-1:0] up_data,
  output logic              up_ready,
  output logic              dn_valid,
  output logic [DATA_W-1:0] dn_data,
  input  logic              dn_ready,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic SKID_EN = (SKID != 0);

  pipe_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              dn_valid_q, dn_valid_d;
  logic              up_ready_q, up_ready_d;
  logic              accept, drain;

  // With SKID=1 the dn_ready term folds away, leaving a pure register output.
  // With SKID=0 the state never reaches SKIDFULL, so up_ready_q stays 1 and
  // up_ready reduces to the combinational !dn_valid || dn_ready.
  assign up_ready = up_ready_q & (SKID_EN | ~dn_valid_q | dn_ready);
  assign dn_valid = dn_valid_q;
  assign dn_data  = main_q;

  always_comb begin
    accept  = up_valid && up_ready && rdy_in && !flush_in;
    drain   = dn_valid_q && dn_ready && rdy_in;
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (rdy_in) begin
      if (flush_in) begin
        state_d = ST_EMPTY;
        main_d  = '0;
        skid_d  = '0;
      end else begin
        case (state_q)
          ST_EMPTY: begin
            if (accept) begin
              state_d = ST_FULL;
              main_d  = up_data;
            end
          end
          ST_FULL: begin
            if (accept && drain) begin
              main_d = up_data;
            end else if (accept && SKID_EN) begin
              state_d = ST_SKIDFULL;
              skid_d  = up_data;
            end else if (drain) begin
              // Zero on the way out so an empty stage presents a NOP.
              state_d = ST_EMPTY;
              main_d  = '0;
            end
          end
          ST_SKIDFULL: begin
            // up_ready is low here, so only the older entry can move.
            if (drain) begin
              state_d = ST_FULL;
              main_d  = skid_q;
              skid_d  = '0;
            end
          end
          default: begin
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
          end
        endcase
      end
    end
    dn_valid_d = (state_d != ST_EMPTY);
    up_ready_d = (state_d != ST_SKIDFULL);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      dn_valid_q <= 1'b0;
      up_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      dn_valid_q <= dn_valid_d;
      up_ready_q <= up_ready_d;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_bubble_cnt (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .inc    (rdy_in && !dn_valid_q),
    .cnt    (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  localparam int DW = 110;
  localparam int CW = 4;
  localparam logic [CW-1:0] BUB_MAX = {CW{1'b1}};

  typedef logic [DW-1:0] pl_t;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          rdy_in;
  logic          flush_in;
  logic          up_valid;
  pl_t           up_data;
  logic          up_ready;
  logic          dn_valid;
  pl_t           dn_data;
  logic          dn_ready;
  logic [CW-1:0] bubble_cnt;

  pipe_stage_reg #(
    .DATA_W (DW),
    .SKID   (1),
    .CNT_W  (CW)
  ) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .flush_in   (flush_in),
    .up_valid   (up_valid),
    .up_data    (up_data),
    .up_ready   (up_ready),
    .dn_valid   (dn_valid),
    .dn_data    (dn_data),
    .dn_ready   (dn_ready),
    .bubble_cnt (bubble_cnt)
  );

  always #5 clk_in = ~clk_in;

  // Scoreboard: the queue holds the payloads the stage should be holding,
  // oldest first. Its depth is the expected occupancy (0/1/2).
  pl_t           sb[$];
  pl_t           out_log[$];
  logic [CW-1:0] m_bub;
  int            n_checks = 0;
  int            n_pass   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_outputs(input string tag);
    pl_t e;
    e = (sb.size() != 0) ? sb[0] : '0;
    chk({tag, ".dn_valid"},   128'(dn_valid),   128'(sb.size() != 0));
    chk({tag, ".up_ready"},   128'(up_ready),   128'(sb.size() != 2));
    chk({tag, ".dn_data"},    128'(dn_data),    128'(e));
    chk({tag, ".bubble_cnt"}, 128'(bubble_cnt), 128'(m_bub));
  endtask

  // One clock: update the scoreboard from the inputs in force, log what the
  // DUT hands downstream, then compare just after the edge.
  task automatic cyc(input string tag);
    logic m_dnv, m_upr, m_acc, m_drn;
    m_dnv = (sb.size() != 0);
    m_upr = (sb.size() != 2);
    m_acc = up_valid && m_upr && rdy_in && !flush_in;
    m_drn = m_dnv && dn_ready && rdy_in && !flush_in;
    if (dn_valid && dn_ready && rdy_in && !flush_in) out_log.push_back(dn_data);
    if (rdy_in && !m_dnv && (m_bub != BUB_MAX)) m_bub = m_bub + 1'b1;
    if (rdy_in && flush_in) begin
      sb.delete();
    end else begin
      if (m_drn) void'(sb.pop_front());
      if (m_acc) sb.push_back(up_data);
    end
    @(posedge clk_in);
    #1;
    check_outputs(tag);
  endtask

  task automatic drive(input logic uv, input pl_t ud, input logic dr);
    up_valid = uv;
    up_data  = ud;
    dn_ready = dr;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n33;

    rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0;
    drive(1'b0, '0, 1'b0);
    m_bub = '0;
    repeat (2) @(posedge clk_in);
    #1;
    chk("reset.dn_valid",   128'(dn_valid),   128'(0));
    chk("reset.dn_data",    128'(dn_data),    128'(0));
    chk("reset.up_ready",   128'(up_ready),   128'(1));
    chk("reset.bubble_cnt", 128'(bubble_cnt), 128'(0));
    rst_in = 1'b0;

    // Single transfer, first edge after reset release.
    drive(1'b1, pl_t'(8'hA5), 1'b1);
    cyc("xfer_a5");
    chk("xfer_a5.data_direct", 128'(dn_data), 128'(8'hA5));
    drive(1'b0, '0, 1'b0);
    cyc("hold_a5");

    // Frozen for 5 cycles with traffic offered on both sides.
    rdy_in = 1'b0;
    drive(1'b1, pl_t'(8'h77), 1'b1);
    for (int i = 0; i < 5; i++) cyc("frozen");
    chk("frozen.data_direct", 128'(dn_data),    128'(8'hA5));
    chk("frozen.bubble_hold", 128'(bubble_cnt), 128'(1));
    rdy_in = 1'b1;
    drive(1'b0, '0, 1'b1);
    cyc("drain_a5");

    // Fill main and skid, offer a third word while full, then drain in order.
    out_log.delete();
    drive(1'b1, pl_t'(8'h11), 1'b0);
    cyc("fill_11");
    drive(1'b1, pl_t'(8'h22), 1'b0);
    cyc("fill_22");
    chk("skidfull.up_ready", 128'(up_ready), 128'(0));
    drive(1'b1, pl_t'(8'h99), 1'b0);
    cyc("blocked_99");
    drive(1'b0, '0, 1'b1);
    cyc("drain_11");
    cyc("drain_22");
    cyc("drain_idle");
    chk("order.count",  128'(out_log.size()), 128'(2));
    chk("order.first",  128'(out_log.size() > 0 ? out_log[0] : '1), 128'(8'h11));
    chk("order.second", 128'(out_log.size() > 1 ? out_log[1] : '1), 128'(8'h22));

    // Flush from SKIDFULL with a word offered in the same cycle.
    out_log.delete();
    drive(1'b1, pl_t'(8'h44), 1'b0);
    cyc("fill_44");
    drive(1'b1, pl_t'(8'h55), 1'b0);
    cyc("fill_55");
    flush_in = 1'b1;
    drive(1'b1, pl_t'(8'h33), 1'b0);
    cyc("flush");
    chk("flush.dn_valid", 128'(dn_valid), 128'(0));
    chk("flush.dn_data",  128'(dn_data),  128'(0));
    chk("flush.up_ready", 128'(up_ready), 128'(1));
    flush_in = 1'b0;
    drive(1'b0, '0, 1'b1);
    repeat (3) cyc("post_flush");
    n33 = 0;
    foreach (out_log[i]) if (out_log[i] == pl_t'(8'h33)) n33++;
    chk("flush.no_33", 128'(n33), 128'(0));
    chk("flush.no_output", 128'(out_log.size()), 128'(0));

    // Flush is ignored while frozen.
    drive(1'b1, pl_t'(8'h66), 1'b0);
    cyc("fill_66");
    rdy_in = 1'b0; flush_in = 1'b1;
    drive(1'b0, '0, 1'b1);
    repeat (2) cyc("frozen_flush");
    chk("frozen_flush.data", 128'(dn_data), 128'(8'h66));
    rdy_in = 1'b1; flush_in = 1'b0;
    cyc("drain_66");

    // Random traffic against the scoreboard.
    for (int i = 0; i < 60; i++) begin
      rdy_in   = ($urandom_range(0, 7) != 0);
      flush_in = ($urandom_range(0, 15) == 0);
      drive($urandom_range(0, 1) == 1,
            pl_t'({$urandom(), $urandom(), $urandom(), $urandom()}),
            $urandom_range(0, 2) != 0);
      cyc("rand");
    end
    rdy_in = 1'b1; flush_in = 1'b0;

    // Asynchronous reset in mid-cycle while FULL.
    drive(1'b1, pl_t'(8'h5A), 1'b0);
    cyc("fill_5a");
    drive(1'b0, '0, 1'b0);
    #3;
    rst_in = 1'b1;
    #1;
    chk("async_rst.dn_valid",   128'(dn_valid),   128'(0));
    chk("async_rst.dn_data",    128'(dn_data),    128'(0));
    chk("async_rst.up_ready",   128'(up_ready),   128'(1));
    chk("async_rst.bubble_cnt", 128'(bubble_cnt), 128'(0));
    #2;
    rst_in = 1'b0;
    sb.delete();
    m_bub = '0;
    drive(1'b1, pl_t'(8'hC3), 1'b1);
    cyc("first_after_rst");
    chk("first_after_rst.data_direct", 128'(dn_data), 128'(8'hC3));
    drive(1'b0, '0, 1'b1);
    cyc("drain_c3");

    // Idle long enough to saturate the bubble counter.
    drive(1'b0, '0, 1'b0);
    for (int i = 0; i < 20; i++) cyc("idle");
    chk("bubble.saturated", 128'(bubble_cnt), 128'(15));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 110, payload width in bits (packed rsd addr/data/we/mem addr/store data/cmdtype).
REQ-002 The block SHALL have parameter SKID, default 1, where 1 selects a 2-entry skid stage and 0 selects a plain 1-entry register.
REQ-003 The block SHALL have parameter CNT_W, default 16, bubble-counter width.
REQ-004 The block SHALL have port clk_in, input, 1 bit, the single clock; everything is sampled on its rising edge.
REQ-005 The block SHALL have port rst_in, input, 1 bit, reset, asynchronous and active-high.
REQ-006 The block SHALL have port rdy_in, input, 1 bit, global enable; when 0, the block is frozen.
REQ-007 The block SHALL have port flush_in, input, 1 bit, kill request (branch mispredict / stall-ctrl bubble).
REQ-008 The block SHALL have port up_valid, input, 1 bit, upstream payload valid.
REQ-009 The block SHALL have port up_data, input, DATA_W bits, upstream payload.
REQ-010 The block SHALL have port up_ready, output, 1 bit, the block can accept.
REQ-011 The block SHALL have port dn_valid, output, 1 bit, downstream payload valid.
REQ-012 The block SHALL have port dn_data, output, DATA_W bits, downstream payload.
REQ-013 The block SHALL have port dn_ready, input, 1 bit, downstream can take.
REQ-014 The block SHALL have port bubble_cnt, output, CNT_W bits, count of enabled cycles with dn_valid=0.

Function
REQ-015 An accept SHALL occur when up_valid && up_ready && rdy_in && !flush_in, and a drain SHALL occur when dn_valid && dn_ready && rdy_in.
REQ-016 Latency SHALL be exactly 1 cycle: a payload accepted at edge N appears on dn_data with dn_valid=1 after edge N.
REQ-017 With SKID=1, the state SHALL be one of EMPTY, FULL, or SKIDFULL: main register plus skid register both valid.
REQ-018 From EMPTY, the state SHALL go to FULL on accept and otherwise stay EMPTY.
REQ-019 From FULL, the state SHALL stay FULL on accept with drain (main loads up_data), go to SKIDFULL on accept without drain (skid loads up_data), go to EMPTY on drain without accept, and otherwise hold.
REQ-020 From SKIDFULL, on drain the main register SHALL take the skid contents and the state SHALL go to FULL; otherwise the state SHALL hold.
REQ-021 With SKID=1, up_ready SHALL be registered and SHALL equal (state != SKIDFULL), with no combinational path from dn_ready.
REQ-022 With SKID=0, the states SHALL be EMPTY and FULL only, and up_ready SHALL be combinational: !dn_valid || dn_ready.
REQ-023 dn_valid SHALL be (state != EMPTY), and dn_data SHALL always be the main register.
REQ-024 While dn_valid=0, dn_data SHALL be all-zero, i.e. a bubble is a NOP with cmdtype 0.
REQ-025 While dn_valid=1 and dn_ready=0, dn_data SHALL hold stable.
REQ-026 Order SHALL be preserved: skid contents never overtake main contents.
REQ-027 flush_in=1 with rdy_in=1 SHALL force the next state to EMPTY and zero both registers; a same-cycle up_valid is discarded, and flush wins over accept and drain.
REQ-028 With rdy_in=0, all state, registers, and bubble_cnt SHALL hold; flush_in is ignored, and no accept or drain occurs.
REQ-029 bubble_cnt SHALL increment by 1 on each rdy_in=1 edge where dn_valid=0 before the edge, and saturate at 2^CNT_W-1 with no wrap.

Reset
REQ-030 On rst_in=1, asynchronously and immediately, the state SHALL go to EMPTY, both registers SHALL be 0, dn_valid=0, dn_data=0, bubble_cnt=0, and up_ready SHALL be 1 (SKID=1) or follow REQ-022 (SKID=0).
REQ-031 Reset asserted mid-transfer SHALL discard held payloads, and no partial payload shall appear after release.
REQ-032 The first accept SHALL be possible on the first rising edge after rst_in deasserts.

Structure
REQ-033 Package pipe_pkg SHALL hold the state enum (EMPTY/FULL/SKIDFULL), the default DATA_W, and the payload field offsets shared with the ex/mem stages.
REQ-034 Saturating counter SHALL be a sub-module sat_counter (parameter CNT_W; inputs clk_in, rst_in, inc; output cnt).
REQ-035 The block SHALL contain no latches and no combinational loop between up_ready and dn_ready when SKID=1.

Verification
REQ-036 The bench SHALL check: reset, then up_valid=1 with data 0xA5 and dn_ready=1 -> dn_valid=1, dn_data=0xA5 one cycle later, and up_ready stays 1.
REQ-037 The bench SHALL check: SKID=1, dn_ready=0, accept 0x11 then 0x22 -> state SKIDFULL, up_ready=0; then dn_ready=1 -> outputs 0x11 then 0x22 in order, with no loss or duplicate.
REQ-038 The bench SHALL check: state SKIDFULL, flush_in=1 with up_valid=1 (0x33) -> next cycle dn_valid=0, dn_data=0, up_ready=1, and 0x33 is never output.
REQ-039 The bench SHALL check: rdy_in=0 for 5 cycles with up_valid=1 and dn_ready=1 -> dn_data and state unchanged, and bubble_cnt unchanged.
REQ-040 The bench SHALL check: CNT_W=4, idle 20 enabled cycles -> bubble_cnt=15 (saturated).
REQ-041 The bench SHALL check: rst_in asserted asynchronously mid-cycle while FULL -> dn_valid=0 and dn_data=0 before the next clock edge.
